// File: rtl/sparc_exu_alu_rdpipe.sv
// ALU result pipeline (E->M->W) with regfile write-back from W and
// D-stage forwarding-select generation against in-flight E/M/W producers.
module sparc_exu_alu_rdpipe #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned TID_W  = 2
) (
    input  logic              rclk,
    input  logic              rst_l,
    input  logic [DATA_W-1:0] alu_byp_rd_data_e,
    input  logic [RD_W-1:0]   ecl_rd_e,
    input  logic [TID_W-1:0]  ecl_tid_e,
    input  logic              ecl_wen_e,
    input  logic              ecl_kill_m,
    input  logic              ecl_stall,
    input  logic [RD_W-1:0]   ifu_rs1_d,
    input  logic [RD_W-1:0]   ifu_rs2_d,
    input  logic [RD_W-1:0]   ifu_rs3_d,
    input  logic [TID_W-1:0]  ifu_tid_d,
    output logic [DATA_W-1:0] byp_rd_data_m,
    output logic [DATA_W-1:0] byp_rd_data_w,
    output logic              exu_irf_wen_w,
    output logic [RD_W-1:0]   exu_irf_rd_w,
    output logic [TID_W-1:0]  exu_irf_tid_w,
    output logic [1:0]        byp_rs1_sel_d,
    output logic [1:0]        byp_rs2_sel_d,
    output logic [1:0]        byp_rs3_sel_d
);

    logic [RD_W-1:0]  rd_m;
    logic [TID_W-1:0] tid_m;
    logic             wen_m;

    // Pipeline registers; a kill during stall drops the M write in place.
    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            byp_rd_data_m <= '0;
            rd_m          <= '0;
            tid_m         <= '0;
            wen_m         <= 1'b0;
            byp_rd_data_w <= '0;
            exu_irf_rd_w  <= '0;
            exu_irf_tid_w <= '0;
            exu_irf_wen_w <= 1'b0;
        end else if (ecl_stall) begin
            if (ecl_kill_m) begin
                wen_m <= 1'b0;
            end
        end else begin
            byp_rd_data_m <= alu_byp_rd_data_e;
            rd_m          <= ecl_rd_e;
            tid_m         <= ecl_tid_e;
            wen_m         <= ecl_wen_e;
            byp_rd_data_w <= byp_rd_data_m;
            exu_irf_rd_w  <= rd_m;
            exu_irf_tid_w <= tid_m;
            exu_irf_wen_w <= wen_m & ~ecl_kill_m;
        end
    end

    // Effective producers; r0 is never a forwarding source.
    logic ven_e, ven_m, ven_w;
    assign ven_e = ecl_wen_e & (ecl_rd_e != '0);
    assign ven_m = wen_m & ~ecl_kill_m & (rd_m != '0);
    assign ven_w = exu_irf_wen_w & (exu_irf_rd_w != '0);

    function automatic logic [1:0] fwd_sel(
        input logic [RD_W-1:0]  rs,
        input logic [TID_W-1:0] tid_d,
        input logic             v_e,
        input logic [RD_W-1:0]  r_e,
        input logic [TID_W-1:0] t_e,
        input logic             v_m,
        input logic [RD_W-1:0]  r_m,
        input logic [TID_W-1:0] t_m,
        input logic             v_w,
        input logic [RD_W-1:0]  r_w,
        input logic [TID_W-1:0] t_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (v_e && (r_e == rs) && (t_e == tid_d)) begin
            sel = 2'b01;
        end else if (v_m && (r_m == rs) && (t_m == tid_d)) begin
            sel = 2'b10;
        end else if (v_w && (r_w == rs) && (t_w == tid_d)) begin
            sel = 2'b11;
        end
        return sel;
    endfunction

    // Youngest matching producer wins: E, then M, then W.
    always_comb begin
        byp_rs1_sel_d = fwd_sel(ifu_rs1_d, ifu_tid_d,
                                ven_e, ecl_rd_e, ecl_tid_e,
                                ven_m, rd_m, tid_m,
                                ven_w, exu_irf_rd_w, exu_irf_tid_w);
        byp_rs2_sel_d = fwd_sel(ifu_rs2_d, ifu_tid_d,
                                ven_e, ecl_rd_e, ecl_tid_e,
                                ven_m, rd_m, tid_m,
                                ven_w, exu_irf_rd_w, exu_irf_tid_w);
        byp_rs3_sel_d = fwd_sel(ifu_rs3_d, ifu_tid_d,
                                ven_e, ecl_rd_e, ecl_tid_e,
                                ven_m, rd_m, tid_m,
                                ven_w, exu_irf_rd_w, exu_irf_tid_w);
    end

endmodule

// File: tb/tb_sparc_exu_alu_rdpipe.sv
// Bench for sparc_exu_alu_rdpipe: directed vector table, then random stimulus
// against a stage-list reference model.
module tb_sparc_exu_alu_rdpipe;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [63:0] data_e;
    logic [4:0]  rd_e;
    logic [1:0]  tid_e;
    logic        wen_e;
    logic        kill_m;
    logic        stall;
    logic [4:0]  rs1, rs2, rs3;
    logic [1:0]  tid_d;
    logic [63:0] data_m, data_w;
    logic        wen_w;
    logic [4:0]  rd_w;
    logic [1:0]  tid_w;
    logic [1:0]  sel1, sel2, sel3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sparc_exu_alu_rdpipe dut (
        .rclk              (clk),
        .rst_l             (rst_l),
        .alu_byp_rd_data_e (data_e),
        .ecl_rd_e          (rd_e),
        .ecl_tid_e         (tid_e),
        .ecl_wen_e         (wen_e),
        .ecl_kill_m        (kill_m),
        .ecl_stall         (stall),
        .ifu_rs1_d         (rs1),
        .ifu_rs2_d         (rs2),
        .ifu_rs3_d         (rs3),
        .ifu_tid_d         (tid_d),
        .byp_rd_data_m     (data_m),
        .byp_rd_data_w     (data_w),
        .exu_irf_wen_w     (wen_w),
        .exu_irf_rd_w      (rd_w),
        .exu_irf_tid_w     (tid_w),
        .byp_rs1_sel_d     (sel1),
        .byp_rs2_sel_d     (sel2),
        .byp_rs3_sel_d     (sel3)
    );

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic [1:0]  tid;
        logic        wen;
    } ent_t;

    typedef struct {
        logic        rst_l, stall, kill, wen;
        logic [4:0]  rd;
        logic [1:0]  tid;
        logic [63:0] data;
        logic [4:0]  rs1, rs2, rs3;
        logic [1:0]  tid_d;
        logic        chk_sel;
        logic [5:0]  sel;
        logic [63:0] dm, dw;
        logic        ww;
        logic [4:0]  rw;
        logic [1:0]  tw;
    } vec_t;

    vec_t vecs[$];
    ent_t mstg, wstg;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference forwarding: list producers youngest first, take first live match.
    function automatic logic [1:0] ref_sel(input logic [4:0] rs);
        ent_t c[3];
        c[0] = '{data_e, rd_e, tid_e, wen_e};
        c[1] = mstg;
        c[1].wen = mstg.wen & ~kill_m;
        c[2] = wstg;
        for (int i = 0; i < 3; i++) begin
            if (c[i].wen && c[i].rd != 5'd0 && c[i].rd == rs && c[i].tid == tid_d)
                return 2'(i + 1);
        end
        return 2'b00;
    endfunction

    task automatic model_edge();
        if (!rst_l) begin
            mstg = '{64'd0, 5'd0, 2'd0, 1'b0};
            wstg = '{64'd0, 5'd0, 2'd0, 1'b0};
        end else if (stall) begin
            if (kill_m) mstg.wen = 1'b0;
        end else begin
            wstg = mstg;
            wstg.wen = mstg.wen & ~kill_m;
            mstg = '{data_e, rd_e, tid_e, wen_e};
        end
    endtask

    task automatic add(input logic r, input logic st, input logic k, input logic w,
                       input logic [4:0] rd, input logic [1:0] tid, input logic [63:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3,
                       input logic [1:0] td, input logic cs, input logic [5:0] sel,
                       input logic [63:0] dm, input logic [63:0] dw, input logic ww,
                       input logic [4:0] rw, input logic [1:0] tw);
        vec_t v;
        v = '{r, st, k, w, rd, tid, d, s1, s2, s3, td, cs, sel, dm, dw, ww, rw, tw};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic st, input logic k, input logic w,
                         input logic [4:0] rd, input logic [1:0] tid, input logic [63:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3,
                         input logic [1:0] td);
        rst_l = r; stall = st; kill_m = k; wen_e = w; rd_e = rd; tid_e = tid;
        data_e = d; rs1 = s1; rs2 = s2; rs3 = s3; tid_d = td;
    endtask

    initial begin
        mstg = '{64'd0, 5'd0, 2'd0, 1'b0};
        wstg = '{64'd0, 5'd0, 2'd0, 1'b0};
        //   rst st k  w  rd  tid data                   rs1 rs2 rs3 tdd chk sel      dm                     dw                     ww rw  tw
        add(0, 0, 0, 1, 3, 0, 64'hDEAD,                0,  0,  0, 0, 0, 6'b000000, 64'h0,                 64'h0,                 0, 0, 0);
        add(0, 0, 0, 1, 3, 0, 64'hDEAD,                0,  0,  0, 0, 1, 6'b000000, 64'h0,                 64'h0,                 0, 0, 0);
        add(1, 0, 0, 1, 5, 1, 64'h0123_4567_89AB_CDEF, 5,  0,  0, 1, 1, 6'b010000, 64'h0123_4567_89AB_CDEF, 64'h0,               0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 64'h0,                   5,  0,  0, 1, 1, 6'b100000, 64'h0,                 64'h0123_4567_89AB_CDEF, 1, 5, 1);
        add(1, 0, 0, 0, 0, 0, 64'h0,                   5,  0,  0, 1, 1, 6'b110000, 64'h0,                 64'h0,                 0, 0, 0);
        add(1, 0, 0, 1, 7, 0, 64'h11,                  7,  0,  0, 0, 1, 6'b010000, 64'h11,                64'h0,                 0, 0, 0);
        add(1, 0, 0, 1, 7, 0, 64'h22,                  7,  0,  0, 0, 1, 6'b010000, 64'h22,                64'h11,                1, 7, 0);
        add(1, 0, 0, 1, 7, 0, 64'h33,                  7,  0,  0, 0, 1, 6'b010000, 64'h33,                64'h22,                1, 7, 0);
        add(1, 0, 0, 0, 0, 0, 64'h0,                   7,  0,  0, 0, 1, 6'b100000, 64'h0,                 64'h33,                1, 7, 0);
        add(1, 0, 0, 0, 0, 0, 64'h0,                   7,  0,  0, 0, 1, 6'b110000, 64'h0,                 64'h0,                 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 64'h0,                   7,  0,  0, 0, 1, 6'b000000, 64'h0,                 64'h0,                 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 64'h55,                  0,  0,  0, 0, 1, 6'b000000, 64'h55,                64'h0,                 0, 0, 0);
        add(1, 0, 0, 1, 4, 1, 64'h66,                  4,  0,  0, 2, 1, 6'b000000, 64'h66,                64'h55,                1, 0, 0);
        add(1, 0, 0, 1, 9, 0, 64'h99,                  0,  0,  9, 0, 1, 6'b000001, 64'h99,                64'h66,                1, 4, 1);
        add(1, 0, 1, 0, 0, 0, 64'h0,                   0,  0,  9, 0, 1, 6'b000000, 64'h0,                 64'h99,                0, 9, 0);
        add(1, 0, 0, 1, 2, 3, 64'hBB,                  0,  0,  0, 0, 1, 6'b000000, 64'hBB,                64'h0,                 0, 0, 0);
        add(1, 0, 0, 1, 3, 3, 64'hAA,                  0,  0,  0, 0, 1, 6'b000000, 64'hAA,                64'hBB,                1, 2, 3);
        add(1, 1, 0, 1, 6, 3, 64'hCC,                  3,  2,  6, 3, 1, 6'b101101, 64'hAA,                64'hBB,                1, 2, 3);
        add(1, 1, 0, 1, 6, 3, 64'hCC,                  3,  2,  6, 3, 1, 6'b101101, 64'hAA,                64'hBB,                1, 2, 3);
        add(1, 1, 0, 1, 6, 3, 64'hCC,                  3,  2,  6, 3, 1, 6'b101101, 64'hAA,                64'hBB,                1, 2, 3);
        add(1, 0, 0, 1, 6, 3, 64'hCC,                  3,  2,  6, 3, 1, 6'b101101, 64'hCC,                64'hAA,                1, 3, 3);
        add(1, 1, 1, 0, 0, 0, 64'hDD,                  6,  0,  0, 3, 1, 6'b000000, 64'hCC,                64'hAA,                1, 3, 3);
        add(1, 0, 0, 0, 0, 0, 64'h0,                   6,  0,  0, 3, 1, 6'b000000, 64'h0,                 64'hCC,                0, 6, 3);
        add(1, 0, 0, 1, 8, 1, 64'hEE,                  0,  0,  0, 0, 1, 6'b000000, 64'hEE,                64'h0,                 0, 0, 0);
        add(0, 0, 0, 1, 8, 1, 64'hEF,                  0,  0,  0, 0, 1, 6'b000000, 64'h0,                 64'h0,                 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 64'h0,                   8,  0,  0, 1, 1, 6'b000000, 64'h0,                 64'h0,                 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_l, vecs[i].stall, vecs[i].kill, vecs[i].wen, vecs[i].rd,
                  vecs[i].tid, vecs[i].data, vecs[i].rs1, vecs[i].rs2, vecs[i].rs3, vecs[i].tid_d);
            #1;
            if (vecs[i].chk_sel)
                check($sformatf("vec%0d sel", i), 64'({sel1, sel2, sel3}), 64'(vecs[i].sel));
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("vec%0d data_m", i), data_m, vecs[i].dm);
            check($sformatf("vec%0d data_w", i), data_w, vecs[i].dw);
            check($sformatf("vec%0d irf_w", i), 64'({wen_w, rd_w, tid_w}),
                  64'({vecs[i].ww, vecs[i].rw, vecs[i].tw}));
        end

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), 1'($urandom),
                  5'($urandom_range(0, 7)), 2'($urandom), {$urandom, $urandom},
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 2'($urandom));
            #1;
            check($sformatf("rnd%0d sel", i), 64'({sel1, sel2, sel3}),
                  64'({ref_sel(rs1), ref_sel(rs2), ref_sel(rs3)}));
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("rnd%0d data_m", i), data_m, mstg.data);
            check($sformatf("rnd%0d data_w", i), data_w, wstg.data);
            check($sformatf("rnd%0d irf_w", i), 64'({wen_w, rd_w, tid_w}),
                  64'({wstg.wen, wstg.rd, wstg.tid}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
